// File: rtl/deser_lane_arbiter.sv
// deser_lane_arbiter: shares one serial deserializer among N_LANES lanes.
// Round-robin grant per word, forwards the granted bit stream, returns the
// captured word tagged with its lane ID, and aborts stalled transfers.
//
// Ports:
//   clk_i, srst_n_i            clock, synchronous active-low reset
//   req_i, data_i, data_val_i  per-lane request, serial bit, bit valid
//   grant_o                    one-hot grant, zero outside STREAM
//   ser_data_o, ser_data_val_o serial bit/valid to the deserializer
//   deser_data_i, deser_data_val_i  word/valid from the deserializer
//   deser_srst_o               active-high reset to the deserializer
//   word_o, word_val_o, word_id_o   captured word, pulse, lane ID
//   busy_o, timeout_o          not-IDLE flag, abort pulse
module deser_lane_arbiter #(
    parameter int N_LANES = 4,
    parameter int WORD_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(N_LANES)
) (
    input  logic               clk_i,
    input  logic               srst_n_i,
    input  logic [N_LANES-1:0] req_i,
    input  logic [N_LANES-1:0] data_i,
    input  logic [N_LANES-1:0] data_val_i,
    output logic [N_LANES-1:0] grant_o,
    output logic               ser_data_o,
    output logic               ser_data_val_o,
    input  logic [WORD_W-1:0]  deser_data_i,
    input  logic               deser_data_val_i,
    output logic               deser_srst_o,
    output logic [WORD_W-1:0]  word_o,
    output logic               word_val_o,
    output logic [ID_W-1:0]    word_id_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] STREAM    = 2'd1;
    localparam logic [1:0] WAIT_WORD = 2'd2;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [N_LANES-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               ser_data_q, ser_data_d;
    logic               ser_val_q, ser_val_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               word_val_q, word_val_d;
    logic [ID_W-1:0]    word_id_q, word_id_d;
    logic               timeout_q, timeout_d;
    logic               deser_srst_q, deser_srst_d;

    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    nxt;
    int                 idx;

    assign nxt = ID_W'((int'(gid_q) + 1) % N_LANES);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gid_d        = gid_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        ser_data_d   = 1'b0;
        ser_val_d    = 1'b0;
        word_d       = word_q;
        word_val_d   = 1'b0;
        word_id_d    = word_id_q;
        timeout_d    = 1'b0;
        deser_srst_d = 1'b0;

        // Scan from the farthest offset down so the nearest requester
        // at or after the pointer is the last one written.
        pick = ptr_q;
        idx  = 0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % N_LANES;
            if (req_i[idx]) pick = ID_W'(idx);
        end

        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    gid_d         = pick;
                    cnt_d         = '0;
                    wd_d          = '0;
                    state_d       = STREAM;
                end
            end
            STREAM: begin
                ser_data_d = data_i[gid_q];
                ser_val_d  = data_val_i[gid_q];
                if (data_val_i[gid_q]) begin
                    wd_d = '0;
                    if (cnt_q == CNT_W'(WORD_W - 1)) begin
                        cnt_d   = '0;
                        grant_d = '0;
                        state_d = WAIT_WORD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d    = 1'b1;
                    deser_srst_d = 1'b1;
                    grant_d      = '0;
                    cnt_d        = '0;
                    wd_d         = '0;
                    ptr_d        = nxt;
                    state_d      = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            WAIT_WORD: begin
                // A word arriving on the last watchdog cycle still wins.
                if (deser_data_val_i) begin
                    word_d     = deser_data_i;
                    word_id_d  = gid_q;
                    word_val_d = 1'b1;
                    wd_d       = '0;
                    ptr_d      = nxt;
                    state_d    = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d    = 1'b1;
                    deser_srst_d = 1'b1;
                    wd_d         = '0;
                    ptr_d        = nxt;
                    state_d      = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gid_q        <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            wd_q         <= '0;
            ser_data_q   <= 1'b0;
            ser_val_q    <= 1'b0;
            word_q       <= '0;
            word_val_q   <= 1'b0;
            word_id_q    <= '0;
            timeout_q    <= 1'b0;
            deser_srst_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gid_q        <= gid_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            ser_data_q   <= ser_data_d;
            ser_val_q    <= ser_val_d;
            word_q       <= word_d;
            word_val_q   <= word_val_d;
            word_id_q    <= word_id_d;
            timeout_q    <= timeout_d;
            deser_srst_q <= deser_srst_d;
        end
    end

    assign grant_o        = grant_q;
    assign ser_data_o     = ser_data_q;
    assign ser_data_val_o = ser_val_q;
    assign deser_srst_o   = deser_srst_q;
    assign word_o         = word_q;
    assign word_val_o     = word_val_q;
    assign word_id_o      = word_id_q;
    assign busy_o         = (state_q != IDLE);
    assign timeout_o      = timeout_q;

endmodule

// File: doc/deser_lane_arbiter.md
Name: deser_lane_arbiter

Overview:
Round-robin scheduler that shares one 16-bit serial deserializer between N_LANES serial requesters. It grants one lane per word and forwards that lane's bit stream to the deserializer. It waits for the deserializer's word-valid, then returns the captured word tagged with the lane ID. A watchdog recovers a stalled transfer by resetting the deserializer.

Parameters:
N_LANES, 4, number of serial requesters (2..16)
WORD_W, 16, bits per word; must equal the deserializer output width
TIMEOUT, 64, max cycles allowed without progress before abort (≥ 4)
ID_W, $clog2(N_LANES), width of the lane ID

Ports:
clk_i  in  1  clock
srst_n_i  in  1  synchronous reset, active-low
req_i  in  N_LANES  per-lane request to send one word
data_i  in  N_LANES  per-lane serial data bit
data_val_i  in  N_LANES  per-lane serial bit valid
grant_o  out  N_LANES  one-hot grant; the lane may stream while its bit is high
ser_data_o  out  1  serial bit to deserializer
ser_data_val_o  out  1  serial bit valid to deserializer
deser_data_i  in  WORD_W  parallel word from deserializer
deser_data_val_i  in  1  word valid from deserializer
deser_srst_o  out  1  active-high synchronous reset to deserializer
word_o  out  WORD_W  captured word
word_val_o  out  1  one-cycle pulse, word_o/word_id_o valid
word_id_o  out  ID_W  lane that produced word_o
busy_o  out  1  high in any state other than IDLE
timeout_o  out  1  one-cycle pulse on abort

Behaviour:
- Reset (srst_n_i=0), values on the next edge:
  - outputs: grant_o=0, ser_*=0, word_o=0, word_val_o=0, word_id_o=0, busy_o=0, timeout_o=0.
  - internal: pointer=0, bit count=0, watchdog=0.
  - deser_srst_o=1; it drops to 0 one cycle after reset deasserts.
- Reset mid-operation aborts everything with no word_val_o.
- FSM states: IDLE, STREAM, WAIT_WORD.
- IDLE:
  - If any req_i bit is set, choose the first requesting lane at or after the pointer, wrapping modulo N_LANES.
  - Register grant_o for that lane and enter STREAM.
  - No request: stay in IDLE.
- STREAM:
  - ser_data_o/ser_data_val_o are data_i[g]/data_val_i[g] registered, giving 1-cycle latency.
  - Bits from non-granted lanes are ignored.
  - The bit count increments on each data_val_i[g]. Gaps in valid are allowed.
  - Dropping req_i mid-word is ignored; the grant holds until WORD_W bits are received.
  - On the WORD_W-th valid bit: clear grant_o on the next edge, clear the count, enter WAIT_WORD.
  - Bit order is unchanged: the first bit becomes bit 0 of the word.
- WAIT_WORD:
  - On deser_data_val_i: word_o=deser_data_i, word_id_o=g, word_val_o pulses for 1 cycle.
  - Then pointer=(g+1) mod N_LANES and the FSM returns to IDLE.
- deser_data_val_i in IDLE or STREAM is spurious and ignored; no word_val_o.
- Watchdog:
  - Counts every cycle in STREAM without data_val_i[g], and every cycle in WAIT_WORD.
  - It clears on each accepted bit and on entry to STREAM.
  - When it reaches TIMEOUT, in the same edge:
    - timeout_o pulses;
    - deser_srst_o pulses for 1 cycle;
    - grant_o clears and the word is discarded;
    - the pointer advances past g;
    - the FSM enters IDLE.
- Throughput: a word costs at least 1 (IDLE) + WORD_W + deserializer latency cycles. IDLE always lasts ≥ 1 cycle between grants.
- grant_o is never multi-hot, and is zero outside STREAM.

Test Plan:
- Single word:
  - Stimulus: lane 2 requests and streams 16 contiguous bits of 0xA5C3, LSB first; a deserializer model responds.
  - Response: grant_o=4'b0100 for 16 valid cycles. Then word_o=0xA5C3, word_id_o=2, word_val_o pulses once.
- Round-robin:
  - Stimulus: lanes 0, 1 and 3 request continuously from reset.
  - Response: grant order 0,1,3,0,1,3. Each word_id_o matches its grant; no lane is granted twice in a row while others wait.
- Valid gaps and foreign traffic:
  - Stimulus: granted lane 1 sends 0x1234 with valid held low 1–3 cycles between bits, while lane 0 toggles data/valid.
  - Response: word_o=0x1234 with word_id_o=1. ser_data_val_o count is exactly 16.
- Deserializer timeout:
  - Stimulus: deser_data_val_i is never asserted after lane 0 finishes, with TIMEOUT=64.
  - Response: 64 cycles into WAIT_WORD, timeout_o and deser_srst_o each pulse 1 cycle, there is no word_val_o, and the next grant goes to lane 1.
- Stalled lane:
  - Stimulus: granted lane 3 sends 5 bits, then holds valid low.
  - Response: timeout 64 cycles after the 5th bit, grant_o=0, pointer wraps to 0.
- Reset mid-stream:
  - Stimulus: assert srst_n_i=0 after 8 bits.
  - Response: on the next edge all outputs are 0 and deser_srst_o=1. After release, lane 0 has top priority and the earlier partial word never appears.
